// File: rtl/avg_pkg.sv
// ---------------------------------------------------------------------------
// avg_pkg
//   Shared definitions for the 8-sample averager and its upstream feeder:
//   default sample width / frame length and the feeder state type.
//   Imported by avg_sample_buf, avg_sample_feeder and the benches.
// ---------------------------------------------------------------------------
package avg_pkg;

  localparam int AVG_DW = 8;
  localparam int AVG_N  = 8;

  typedef enum logic [1:0] {
    FILL,
    START,
    SEND,
    WAIT
  } feed_state_t;

endpackage

// File: rtl/avg_sample_buf.sv
// ---------------------------------------------------------------------------
// avg_sample_buf
//   N x DW frame buffer: one synchronous write port and one combinational
//   read port. Contents are deliberately not reset; a frame is always fully
//   rewritten before it is read.
// Ports
//   i_clk      clock, rising edge
//   i_wr_en    write strobe
//   i_wr_addr  write address [CW-1:0]
//   i_wr_data  write data [DW-1:0]
//   i_rd_addr  read address [CW-1:0]
//   o_rd_data  read data [DW-1:0], combinational from i_rd_addr
// ---------------------------------------------------------------------------
module avg_sample_buf
  import avg_pkg::*;
#(
  parameter  int DW = AVG_DW,
  parameter  int N  = AVG_N,
  localparam int CW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [CW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [CW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [N];

  // Store one sample per accepted handshake; no reset on the array.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/avg_sample_feeder.sv
// ---------------------------------------------------------------------------
// avg_sample_feeder
//   Collects N samples over a valid/ready handshake, then pulses o_avg_start
//   and streams the frame to the averager one sample per clock. It waits for
//   i_avg_ready before taking the next frame, so the averager only ever sees
//   complete, unstalled frames.
// Ports
//   i_clk             clock, rising edge
//   i_rst             asynchronous, active-high reset
//   i_in_valid        source presents i_in_data
//   i_in_data         input sample [DW-1:0]
//   o_in_ready        feeder accepts a sample this cycle
//   o_avg_start       one-cycle start pulse to the averager
//   o_avg_data        sample to the averager [DW-1:0], 0 when not valid
//   o_avg_data_valid  o_avg_data carries a frame sample
//   i_avg_ready       averager ready (result done / idle)
//   o_busy            frame held or in flight
//   o_frame_cnt       completed frames [15:0] (only with FEEDER_FRAME_CNT_EN)
// Configuration
//   FEEDER_FRAME_CNT_EN  adds o_frame_cnt, counting WAIT->FILL transitions.
// ---------------------------------------------------------------------------
module avg_sample_feeder
  import avg_pkg::*;
#(
  parameter  int DW = AVG_DW,
  parameter  int N  = AVG_N,
  localparam int CW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_in_ready,
  output logic          o_avg_start,
  output logic [DW-1:0] o_avg_data,
  output logic          o_avg_data_valid,
  input  logic          i_avg_ready,
  output logic          o_busy
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0]   o_frame_cnt
`endif
);

  feed_state_t   r_state;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic          r_in_ready;
  logic          r_avg_start;
  logic [DW-1:0] r_avg_data;
  logic          r_avg_valid;
  logic          r_busy;

  logic          w_wr_en;
  logic [CW-1:0] w_rd_addr;
  logic [DW-1:0] w_rd_data;

  assign w_wr_en = (r_state == FILL) && r_in_ready && i_in_valid;

  // The output register is loaded one cycle ahead, so the read port looks at
  // the sample after the one currently on o_avg_data (sample 0 from START).
  assign w_rd_addr = (r_state == SEND) ? CW'(r_rd_cnt + 1'b1) : '0;

  avg_sample_buf #(
    .DW (DW),
    .N  (N)
  ) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data (i_in_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Frame sequencer; every output is a flop loaded with the value for the
  // state being entered, so outputs change cleanly on the clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= FILL;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_in_ready  <= 1'b0;
      r_avg_start <= 1'b0;
      r_avg_data  <= '0;
      r_avg_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (r_wr_cnt == CW'(N - 1)) begin
              r_state     <= START;
              r_in_ready  <= 1'b0;
              r_avg_start <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        START: begin
          r_state     <= SEND;
          r_avg_start <= 1'b0;
          r_rd_cnt    <= '0;
          r_avg_valid <= 1'b1;
          r_avg_data  <= w_rd_data;
        end
        SEND: begin
          if (r_rd_cnt == CW'(N - 1)) begin
            r_state     <= WAIT;
            r_rd_cnt    <= '0;
            r_avg_valid <= 1'b0;
            r_avg_data  <= '0;
          end else begin
            r_rd_cnt   <= r_rd_cnt + 1'b1;
            r_avg_data <= w_rd_data;
          end
        end
        WAIT: begin
          if (i_avg_ready) begin
            r_state    <= FILL;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign o_in_ready       = r_in_ready;
  assign o_avg_start      = r_avg_start;
  assign o_avg_data       = r_avg_data;
  assign o_avg_data_valid = r_avg_valid;
  assign o_busy           = r_busy;

`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts frames handed back to the source; wraps naturally at 16 bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
    end else if ((r_state == WAIT) && i_avg_ready) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  // Frame counter not built in this configuration.
`endif

endmodule
